dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates a single-port data memory between two requesters: the MIPS core's data port and a loader/debug port used by the testbed to preload or inspect memory. It sits between `core` and the data memory, issuing one access at a time. It stalls the losing requester through a request/grant handshake and routes read data back to the owner of the outstanding read.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `MEM_LAT`, default 1: memory read latency in cycles, legal range 1..4.

- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, synchronous and active-low.
- `i_c_req`, in, 1: core requests an access.
- `i_c_wen`, in, 1: core access is a write (1) or a read (0).
- `i_c_addr`, in, AW: core address.
- `i_c_wdata`, in, DW: core write data.
- `o_c_gnt`, out, 1: core access issued this cycle (1-cycle pulse).
- `o_c_rvalid`, out, 1: core read data valid (1-cycle pulse).
- `o_c_rdata`, out, DW: core read data.
- `i_l_req`, `i_l_wen`, `i_l_addr`, `i_l_wdata`, `o_l_gnt`, `o_l_rvalid`, `o_l_rdata`: loader port, same meanings as the core port.
- `o_m_en`, out, 1: memory command strobe.
- `o_m_wen`, out, 1: memory write enable.
- `o_m_addr`, out, AW: memory address.
- `o_m_wdata`, out, DW: memory write data.
- `i_m_rdata`, in, DW: memory read data, valid `MEM_LAT` cycles after the read command.

## Operation
- **State machine:**
  - `IDLE`: accepts a request.
  - `RD_WAIT`: a read is outstanding; a down-counter `lat_cnt` is loaded with `MEM_LAT`.
  - Owner flag `rd_owner` (0 = core, 1 = loader) records which port owns the outstanding read.
- **Grant (one per cycle, combinational from registered state):** allowed when state is `IDLE`, or when state is `RD_WAIT` with `lat_cnt == 1` (back-to-back at the data-return cycle).
  - On grant, the winner's request drives `o_m_*` in the same cycle with `o_m_en = 1`.
  - The matching `o_*_gnt` pulses high.
- **Write grant:** the next state is `IDLE`, with no rvalid.
- **Read grant:** the next state is `RD_WAIT`, `lat_cnt = MEM_LAT`, and `rd_owner` is set to the winner.
- **`RD_WAIT` behaviour:** `lat_cnt` decrements each cycle.
  - In the cycle where `lat_cnt == 1`, the owner's `o_*_rvalid = 1`.
  - In that same cycle, `o_*_rdata = i_m_rdata` for the owner.
  - The state then returns to `IDLE`, unless a new read is granted in that same cycle.
- **Request rules:** a requester holds `req`, `wen`, `addr` and `wdata` stable until it sees `gnt`.
  - Deasserting `req` before grant is legal and withdraws the request.
- **Non-owner outputs:** `o_*_rdata` on the non-owner port is 0; `o_m_*` are 0 when `o_m_en = 0`.
- **Simultaneous requests:** resolved by the policy below (see Configuration).
- **Reset (`i_rst_n = 0` at a clock edge):**
  - state goes to `IDLE`, `lat_cnt = 0`, `rd_owner = 0`, round-robin pointer = core.
  - All outputs are 0 in the following cycle.
  - Any outstanding read is dropped, so no rvalid is produced after reset.

## Timing
- **Grant latency:** 0 cycles when idle and uncontested (`gnt` in the same cycle as `req`).
- **Read data:** `rvalid` occurs exactly `MEM_LAT` cycles after `gnt`.
- **Throughput:** one write per cycle; one read every `MEM_LAT` cycles.
- **Reset state:** all outputs 0.

## Configuration
- **Macro `DMEM_ARB_RR_EN`:**
  - Defined: round-robin arbitration. A 1-bit pointer `rr_last` records the last granted port, and the other port wins a tie. The pointer updates on every grant.
  - Undefined: fixed priority, loader beats core. There is no pointer register, so the core may starve while the loader holds `req`.

## Structure
- **Shared package `dmem_arb_pkg`:** state enum `{IDLE, RD_WAIT}`, port-id constants `PORT_CORE = 0` and `PORT_LDR = 1`, and the `MEM_LAT` legal-range constants.
- **Sub-module `dmem_arb_pick`:** a natural split. It takes both requests and the pointer (combinational) and outputs a one-hot winner. All sequencing stays in the top-level module.

## Test plan
- **Core read uncontested:** `MEM_LAT = 1`, core reads `0x10` with memory returning `0xDEADBEEF` → `o_c_gnt` and `o_m_en` in cycle 0; `o_c_rvalid = 1` with `o_c_rdata = 0xDEADBEEF` in cycle 1; `o_l_*` stay 0.
- **Simultaneous writes:** both ports write (core `0x4 ← 1`, loader `0x8 ← 2`) in the same cycle.
  - With `DMEM_ARB_RR_EN` → loader first (pointer reset = core last), core next cycle.
  - Without it → loader first.
- **Contested reads, `MEM_LAT = 3`:** loader reads `0x20` while core reads `0x24` → second grant no earlier than 3 cycles after the first; each rvalid goes only to its owner, carrying the correct data.
- **Starvation check, fixed priority:** loader holds `req` for 5 cycles while core requests → core sees no grant.
  - With round-robin instead → grants alternate L, C, L, C.
- **Reset mid-read:** `MEM_LAT = 4`, core read granted, `i_rst_n` low in cycle 2 → no `o_c_rvalid` ever; all outputs 0; next core request granted immediately after reset release.
- **Request withdrawal:** core `req` drops during loader `RD_WAIT` before its grant → no core grant, no memory access to the core address.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   port identifiers and the supported memory read-latency range.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LDR  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  // Wide enough to hold MEM_LAT_MAX.
  localparam int LAT_W = 3;

  // Pins a requested latency into the supported range.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Combinational winner selection between the core and loader ports.
//   On a tie, the port that was NOT granted last wins. Tying `last` to
//   PORT_CORE gives fixed loader-over-core priority.
// Ports:
//   c_req  - core request
//   l_req  - loader request
//   last   - port granted most recently (PORT_CORE / PORT_LDR)
//   win    - one-hot winner: win[0] = core, win[1] = loader
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       c_req,
  input  logic       l_req,
  input  logic       last,
  output logic [1:0] win
);

  assign win[0] = c_req & (~l_req | (last == PORT_LDR));
  assign win[1] = l_req & (~c_req | (last == PORT_CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the MIPS core data port and
//   a loader/debug port. One access is issued per cycle; reads are tracked
//   until their data returns MEM_LAT cycles later and routed to their owner.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin arbitration;
//   otherwise the loader has fixed priority over the core.
//
// Ports:
//   i_clk, i_rst_n            - clock, synchronous active-low reset
//   i_c_* / o_c_*             - core port: req, wen, addr, wdata / gnt, rvalid, rdata
//   i_l_* / o_l_*             - loader port, same meanings
//   o_m_en, o_m_wen,
//   o_m_addr, o_m_wdata       - memory command (all zero when o_m_en = 0)
//   i_m_rdata                 - memory read data, valid MEM_LAT cycles after a read
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no read outstanding; any request may be granted
// RD_WAIT | read outstanding; lat_cnt counts down to the data-return cycle,
//         | where a new grant may be issued back-to-back
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,

  input  logic          i_c_req,
  input  logic          i_c_wen,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic          o_c_gnt,
  output logic          o_c_rvalid,
  output logic [DW-1:0] o_c_rdata,

  input  logic          i_l_req,
  input  logic          i_l_wen,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_l_rvalid,
  output logic [DW-1:0] o_l_rdata,

  output logic          o_m_en,
  output logic          o_m_wen,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata
);

  localparam int LAT = clamp_lat(MEM_LAT);

  arb_state_t       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             rd_owner;
  logic             rr_last;

  logic             lat_last;
  logic             gnt_ok;
  logic [1:0]       win;
  logic             gnt_c;
  logic             gnt_l;
  logic             rd_grant;

  // Data-return cycle of the outstanding read.
  assign lat_last = (state == RD_WAIT) && (lat_cnt == LAT_W'(1));

  // Grants and rvalid are held off while reset is asserted so the block is
  // silent for the whole reset cycle, not just after it.
  assign gnt_ok = i_rst_n && ((state == IDLE) || lat_last);

  dmem_arb_pick u_pick (
    .c_req (i_c_req),
    .l_req (i_l_req),
    .last  (rr_last),
    .win   (win)
  );

  assign gnt_c    = gnt_ok & win[0];
  assign gnt_l    = gnt_ok & win[1];
  assign rd_grant = (gnt_c & ~i_c_wen) | (gnt_l & ~i_l_wen);

  assign o_c_gnt = gnt_c;
  assign o_l_gnt = gnt_l;

  assign o_c_rvalid = i_rst_n & lat_last & (rd_owner == PORT_CORE);
  assign o_l_rvalid = i_rst_n & lat_last & (rd_owner == PORT_LDR);
  assign o_c_rdata  = o_c_rvalid ? i_m_rdata : '0;
  assign o_l_rdata  = o_l_rvalid ? i_m_rdata : '0;

  always_comb begin
    o_m_en    = gnt_c | gnt_l;
    o_m_wen   = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    if (gnt_l) begin
      o_m_wen   = i_l_wen;
      o_m_addr  = i_l_addr;
      o_m_wdata = i_l_wdata;
    end else if (gnt_c) begin
      o_m_wen   = i_c_wen;
      o_m_addr  = i_c_addr;
      o_m_wdata = i_c_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      rd_owner <= PORT_CORE;
    end else begin
      if (state == RD_WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
        if (lat_last) state <= IDLE;
      end
      // A read granted in the data-return cycle overrides the return to IDLE.
      if (rd_grant) begin
        state    <= RD_WAIT;
        lat_cnt  <= LAT_W'(LAT);
        rd_owner <= gnt_l ? PORT_LDR : PORT_CORE;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_last <= PORT_CORE;
    end else if (gnt_l) begin
      rr_last <= PORT_LDR;
    end else if (gnt_c) begin
      rr_last <= PORT_CORE;
    end
  end
`else
  assign rr_last = PORT_CORE;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  typedef struct packed {
    logic        rst;
    logic        c_req;
    logic        c_wen;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        l_req;
    logic        l_wen;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
  } in_t;

  typedef struct packed {
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic        m_en;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
  } obs_t;

  typedef struct packed {
    in_t  in;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        c_req = 1'b0, c_wen = 1'b0, l_req = 1'b0, l_wen = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- three DUTs: MEM_LAT = 1, 3, 4 ----------------
  logic        c_gnt_1, c_rv_1, l_gnt_1, l_rv_1, m_en_1, m_wen_1;
  logic [31:0] c_rd_1, l_rd_1, m_addr_1, m_wd_1, m_rd_1;
  logic        c_gnt_3, c_rv_3, l_gnt_3, l_rv_3, m_en_3, m_wen_3;
  logic [31:0] c_rd_3, l_rd_3, m_addr_3, m_wd_3, m_rd_3;
  logic        c_gnt_4, c_rv_4, l_gnt_4, l_rv_4, m_en_4, m_wen_4;
  logic [31:0] c_rd_4, l_rd_4, m_addr_4, m_wd_4, m_rd_4;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt_1), .o_c_rvalid(c_rv_1), .o_c_rdata(c_rd_1),
    .i_l_req(l_req), .i_l_wen(l_wen), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt_1), .o_l_rvalid(l_rv_1), .o_l_rdata(l_rd_1),
    .o_m_en(m_en_1), .o_m_wen(m_wen_1), .o_m_addr(m_addr_1), .o_m_wdata(m_wd_1),
    .i_m_rdata(m_rd_1));

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt_3), .o_c_rvalid(c_rv_3), .o_c_rdata(c_rd_3),
    .i_l_req(l_req), .i_l_wen(l_wen), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt_3), .o_l_rvalid(l_rv_3), .o_l_rdata(l_rd_3),
    .o_m_en(m_en_3), .o_m_wen(m_wen_3), .o_m_addr(m_addr_3), .o_m_wdata(m_wd_3),
    .i_m_rdata(m_rd_3));

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) u_lat4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt_4), .o_c_rvalid(c_rv_4), .o_c_rdata(c_rd_4),
    .i_l_req(l_req), .i_l_wen(l_wen), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt_4), .o_l_rvalid(l_rv_4), .o_l_rdata(l_rd_4),
    .o_m_en(m_en_4), .o_m_wen(m_wen_4), .o_m_addr(m_addr_4), .o_m_wdata(m_wd_4),
    .i_m_rdata(m_rd_4));

  obs_t obs1, obs3, obs4;
  assign obs1 = {c_gnt_1, c_rv_1, c_rd_1, l_gnt_1, l_rv_1, l_rd_1, m_en_1, m_wen_1, m_addr_1, m_wd_1};
  assign obs3 = {c_gnt_3, c_rv_3, c_rd_3, l_gnt_3, l_rv_3, l_rd_3, m_en_3, m_wen_3, m_addr_3, m_wd_3};
  assign obs4 = {c_gnt_4, c_rv_4, c_rd_4, l_gnt_4, l_rv_4, l_rd_4, m_en_4, m_wen_4, m_addr_4, m_wd_4};

  // ---------------- memory models: read data after N cycles ----------------
  logic        v1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [2:0]  v3 = '0;
  logic [31:0] a3 [3];
  logic [3:0]  v4 = '0;
  logic [31:0] a4 [4];

  always @(posedge clk) begin
    v1    <= m_en_1 & ~m_wen_1;
    a1    <= m_addr_1;
    v3    <= {v3[1:0], m_en_3 & ~m_wen_3};
    a3[0] <= m_addr_3;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
    v4    <= {v4[2:0], m_en_4 & ~m_wen_4};
    a4[0] <= m_addr_4;
    a4[1] <= a4[0];
    a4[2] <= a4[1];
    a4[3] <= a4[2];
  end

  assign m_rd_1 = v1    ? mem_val(a1)    : 32'hBAD0BAD0;
  assign m_rd_3 = v3[2] ? mem_val(a3[2]) : 32'hBAD0BAD0;
  assign m_rd_4 = v4[3] ? mem_val(a4[3]) : 32'hBAD0BAD0;

  // ---------------- vector helpers ----------------
  localparam logic C = 1'b0;
  localparam logic L = 1'b1;

  function automatic in_t cr(input logic wen, input logic [31:0] a, input logic [31:0] d);
    in_t r = '0;
    r.c_req = 1'b1; r.c_wen = wen; r.c_addr = a; r.c_wdata = d;
    return r;
  endfunction

  function automatic in_t lr(input logic wen, input logic [31:0] a, input logic [31:0] d);
    in_t r = '0;
    r.l_req = 1'b1; r.l_wen = wen; r.l_addr = a; r.l_wdata = d;
    return r;
  endfunction

  function automatic in_t rst_in();
    in_t r = '0;
    r.rst = 1'b1;
    return r;
  endfunction

  // Grant to `port`, with the memory command it must produce.
  function automatic obs_t g(input logic port, input logic wen, input logic [31:0] a,
                             input logic [31:0] d);
    obs_t r = '0;
    if (port == L) r.l_gnt = 1'b1; else r.c_gnt = 1'b1;
    r.m_en = 1'b1; r.m_wen = wen; r.m_addr = a; r.m_wdata = d;
    return r;
  endfunction

  function automatic obs_t rv(input logic port, input logic [31:0] d);
    obs_t r = '0;
    if (port == L) begin r.l_rvalid = 1'b1; r.l_rdata = d; end
    else           begin r.c_rvalid = 1'b1; r.c_rdata = d; end
    return r;
  endfunction

  function automatic vec_t mk(input in_t i, input obs_t e);
    vec_t r;
    r.in = i; r.exp = e;
    return r;
  endfunction

  function automatic obs_t act_of(input int which);
    if (which == 3) return obs3;
    if (which == 4) return obs4;
    return obs1;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare before the rising edge.
  task automatic step(input int which, input vec_t v, input string name);
    @(negedge clk);
    rst_n   = ~v.in.rst;
    c_req   = v.in.c_req;  c_wen = v.in.c_wen;  c_addr = v.in.c_addr;  c_wdata = v.in.c_wdata;
    l_req   = v.in.l_req;  l_wen = v.in.l_wen;  l_addr = v.in.l_addr;  l_wdata = v.in.l_wdata;
    #2;
    check(name, act_of(which), v.exp);
  endtask

  vec_t seq[$];

  task automatic run_seq(input int which, input string name);
    for (int i = 0; i < seq.size(); i++)
      step(which, seq[i], $sformatf("%s_c%0d", name, i));
    seq.delete();
  endtask

  task automatic do_reset();
    step(1, mk(rst_in(), '0), "in_reset");
    step(1, mk('0, '0), "reset_state_lat1");
    check("reset_state_lat3", obs3, '0);
    check("reset_state_lat4", obs4, '0);
  endtask

  vec_t tbl [10];

  initial begin
    int lk;
    obs_t e;

    // ---- table-driven sequence on the MEM_LAT=1 instance ----
    tbl[0] = mk(cr(0, 32'h10, 0), g(C, 0, 32'h10, 0));
    tbl[1] = mk('0, rv(C, 32'hDEADBEEF));
    tbl[2] = mk(cr(1, 32'h4, 1) | lr(1, 32'h8, 2), g(L, 1, 32'h8, 2));
    tbl[3] = mk(cr(1, 32'h4, 1), g(C, 1, 32'h4, 1));
    tbl[4] = mk(cr(1, 32'h14, 5) | lr(1, 32'hC, 3), g(L, 1, 32'hC, 3));
`ifdef DMEM_ARB_RR_EN
    tbl[5] = mk(cr(1, 32'h14, 5) | lr(1, 32'h18, 6), g(C, 1, 32'h14, 5));
`else
    tbl[5] = mk(cr(1, 32'h14, 5) | lr(1, 32'h18, 6), g(L, 1, 32'h18, 6));
`endif
    tbl[6] = mk(lr(0, 32'h30, 0), g(L, 0, 32'h30, 0));
    tbl[7] = mk(cr(0, 32'h34, 0), g(C, 0, 32'h34, 0) | rv(L, mem_val(32'h30)));
    tbl[8] = mk('0, rv(C, mem_val(32'h34)));
    tbl[9] = mk('0, '0);

    do_reset();
    for (int i = 0; i < 10; i++)
      step(1, tbl[i], $sformatf("tbl%0d", i));

    // ---- starvation / alternation: loader holds req 5 cycles (MEM_LAT=1) ----
    do_reset();
    lk = 0;
    for (int k = 0; k < 5; k++) begin
`ifdef DMEM_ARB_RR_EN
      if ((k % 2) == 0) e = g(L, 1, 32'h60 + 32'(4 * lk), 32'(lk));
      else              e = g(C, 1, 32'h70, 7);
`else
      e = g(L, 1, 32'h60 + 32'(4 * lk), 32'(lk));
`endif
      step(1, mk(cr(1, 32'h70, 7) | lr(1, 32'h60 + 32'(4 * lk), 32'(lk)), e),
           $sformatf("starve_c%0d", k));
      if (e.l_gnt) lk++;
    end

    // ---- contested reads, MEM_LAT=3 ----
    do_reset();
    seq.push_back(mk(lr(0, 32'h20, 0) | cr(0, 32'h24, 0), g(L, 0, 32'h20, 0)));
    seq.push_back(mk(cr(0, 32'h24, 0), '0));
    seq.push_back(mk(cr(0, 32'h24, 0), '0));
    seq.push_back(mk(cr(0, 32'h24, 0), g(C, 0, 32'h24, 0) | rv(L, mem_val(32'h20))));
    seq.push_back(mk('0, '0));
    seq.push_back(mk('0, '0));
    seq.push_back(mk('0, rv(C, mem_val(32'h24))));
    seq.push_back(mk('0, '0));
    run_seq(3, "contest");

    // ---- request withdrawal during loader read, MEM_LAT=3 ----
    do_reset();
    seq.push_back(mk(lr(0, 32'h50, 0), g(L, 0, 32'h50, 0)));
    seq.push_back(mk(cr(0, 32'h54, 0), '0));
    seq.push_back(mk('0, '0));
    seq.push_back(mk('0, rv(L, mem_val(32'h50))));
    seq.push_back(mk('0, '0));
    seq.push_back(mk('0, '0));
    run_seq(3, "withdraw");

    // ---- reset during an outstanding read, MEM_LAT=4 ----
    do_reset();
    seq.push_back(mk(cr(0, 32'h40, 0), g(C, 0, 32'h40, 0)));
    seq.push_back(mk('0, '0));
    seq.push_back(mk(rst_in(), '0));
    for (int i = 0; i < 4; i++) seq.push_back(mk('0, '0));
    seq.push_back(mk(cr(0, 32'h44, 0), g(C, 0, 32'h44, 0)));
    for (int i = 0; i < 3; i++) seq.push_back(mk('0, '0));
    seq.push_back(mk('0, rv(C, mem_val(32'h44))));
    seq.push_back(mk('0, '0));
    run_seq(4, "rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
